subtrator_serial: RTL and testbench

Parametrised multi-cycle subtractor computing D = A − B − Bin over WIDTH bits, STEP bits per clock, with start/busy/done handshake. Next generation of the combinational half/full subtractor cells: one chain of STEP full-subtractor cells is reused every cycle, and the borrow is carried in a register between cycles. It serves as the arithmetic unit for the team's multi-bit datapath exercises, where area matters more than latency.

---
 rtl/subtrator_pkg.sv | 15 +
 rtl/subtrator_completo.sv | 13 +
 rtl/subtrator_serial.sv | 141 ++++++++++++++
 tb/tb_subtrator_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/subtrator_pkg.sv
// rtl/subtrator_pkg.sv - shared state encoding and counter sizing for subtrator_serial
package subtrator_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } state_t;

  // Counter must hold 0..N-1; a single-step configuration still needs one bit.
  function automatic int cnt_width(input int n_steps);
    return (n_steps <= 1) ? 1 : $clog2(n_steps);
  endfunction

endpackage

// File: rtl/subtrator_completo.sv
// rtl/subtrator_completo.sv - 1-bit full subtractor cell: d = a - b - bin
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial.sv
// rtl/subtrator_serial.sv - multi-cycle WIDTH-bit subtractor, STEP bits per clock; SUBTRATOR_OVF_EN adds ovf
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUBTRATOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_width(N);

  if ((WIDTH < 2) || (STEP < 1) || (WIDTH % STEP != 0)) begin : g_bad_params
    $error("subtrator_serial: WIDTH must be >= 2 and divisible by STEP");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               brw_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   d_q;
  logic               bout_q;
  logic               accept;
  logic               last;
  logic [STEP:0]      bw;
  logic [STEP-1:0]    diff;
  logic [WIDTH-1:0]   part_next;

  // One chain of STEP cells, reused every CALC cycle with the registered borrow.
  assign bw[0] = brw_q;
  for (genvar i = 0; i < STEP; i++) begin : g_cell
    subtrator_completo u_fs (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .bin  (bw[i]),
      .d    (diff[i]),
      .bout (bw[i+1])
    );
  end

  // Fresh difference bits enter at the top; after N steps the LSBs have reached bit 0.
  if (STEP < WIDTH) begin : g_part
    logic [WIDTH-STEP-1:0] part_q;
    assign part_next = {diff, part_q};
    always_ff @(posedge clk) begin
      if (rst) begin
        part_q <= '0;
      end else if (state_q == CALC) begin
        part_q <= part_next[WIDTH-1:STEP];
      end
    end
  end else begin : g_nopart
    assign part_next = diff;
  end

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_d = FIM;
      end
      FIM: begin
        done    = 1'b1;
        state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCIOSO;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        brw_q <= bin;
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        a_q   <= a_q >> STEP;
        b_q   <= b_q >> STEP;
        brw_q <= bw[STEP];
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          d_q    <= part_next;
          bout_q <= bw[STEP];
        end
      end
    end
  end

  assign d    = d_q;
  assign bout = bout_q;

`ifdef SUBTRATOR_OVF_EN
  logic ovf_q;
  // Signed overflow: borrow into the MSB cell differs from the borrow leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if ((state_q == CALC) && last) begin
      ovf_q <= bw[STEP-1] ^ bw[STEP];
    end
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// tb/tb_subtrator_serial.sv - scoreboard bench for subtrator_serial (STEP=1 and STEP=4 instances)
module tb_subtrator_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, bin1, busy1, done1, bout1;
  logic [7:0] a1, b1, d1;
  logic       start4, bin4, busy4, done4, bout4;
  logic [7:0] a4, b4, d4;
`ifdef SUBTRATOR_OVF_EN
  logic       ovf1, ovf4;
`endif

  subtrator_serial #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .d(d1), .bout(bout1)
`ifdef SUBTRATOR_OVF_EN
    , .ovf(ovf1)
`endif
  );

  subtrator_serial #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .bout(bout4)
`ifdef SUBTRATOR_OVF_EN
    , .ovf(ovf4)
`endif
  );

  typedef struct packed {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t m;
    logic [8:0] r;
    r      = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    m.d    = r[7:0];
    m.bout = r[8];
    m.ovf  = (a[7] ^ b[7]) & (r[7] ^ a[7]);
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_d", d1, e.d);
        check("dut1_bout", bout1, e.bout);
`ifdef SUBTRATOR_OVF_EN
        check("dut1_ovf", ovf1, e.ovf);
`endif
      end
    end
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("dut4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        check("dut4_d", d4, e.d);
        check("dut4_bout", bout4, e.bout);
`ifdef SUBTRATOR_OVF_EN
        check("dut4_ovf", ovf4, e.ovf);
`endif
      end
    end
  end

  // Issue one operation, scramble operands after acceptance, then check latency and busy length.
  task automatic run_op(input bit use4, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input exp_t e, input string tag);
    int lat  = 0;
    int bcnt = 0;
    bit seen = 0;
    int n    = use4 ? 2 : 8;
    @(negedge clk);
    if (use4) begin a4 = a; b4 = b; bin4 = bin; start4 = 1'b1; q4.push_back(e); end
    else      begin a1 = a; b1 = b; bin1 = bin; start1 = 1'b1; q1.push_back(e); end
    @(posedge clk);
    #1;
    if (use4) begin start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin; end
    else      begin start1 = 1'b0; a1 = ~a; b1 = ~b; bin1 = ~bin; end
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (use4 ? busy4 : busy1) bcnt++;
      if (use4 ? done4 : done1) seen = 1;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_latency"}, lat, n + 1);
    check({tag, "_busy_cycles"}, bcnt, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int   lat;
    bit   seen;
    logic [7:0] ra, rb;
    logic rbin;

    rst = 1'b1;
    start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy1", busy1, 0);
    check("reset_done1", done1, 0);
    check("reset_d1", d1, 0);
    check("reset_bout1", bout1, 0);
    check("reset_busy4", busy4, 0);
    check("reset_d4", d4, 0);
`ifdef SUBTRATOR_OVF_EN
    check("reset_ovf1", ovf1, 0);
`endif

    run_op(0, 8'h05, 8'h03, 0, '{d: 8'h02, bout: 1'b0, ovf: 1'b0}, "s1_05m03");
    run_op(0, 8'h03, 8'h05, 0, '{d: 8'hFE, bout: 1'b1, ovf: 1'b0}, "s1_03m05");
    run_op(0, 8'h00, 8'h00, 1, '{d: 8'hFF, bout: 1'b1, ovf: 1'b0}, "s1_00m00b");
    repeat (3) @(negedge clk);
    check("hold_d1", d1, 8'hFF);
    check("hold_bout1", bout1, 1);
    run_op(0, 8'h80, 8'h01, 0, '{d: 8'h7F, bout: 1'b0, ovf: 1'b1}, "s1_80m01");
    run_op(0, 8'h10, 8'h01, 0, '{d: 8'h0F, bout: 1'b0, ovf: 1'b0}, "s1_10m01");

    // start held high, operands disturbed during CALC
    @(negedge clk);
    a1 = 8'h05; b1 = 8'h03; bin1 = 0; start1 = 1'b1;
    q1.push_back('{d: 8'h02, bout: 1'b0, ovf: 1'b0});
    @(posedge clk);
    #1 a1 = 8'hC3; b1 = 8'h3C; bin1 = 1;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk); lat++;
      if (done1) seen = 1;
    end
    check("held_done_seen", 32'(seen), 1);
    check("held_latency", lat, 9);
    a1 = 8'h30; b1 = 8'h10; bin1 = 0;
    q1.push_back('{d: 8'h20, bout: 1'b0, ovf: 1'b0});
    @(negedge clk);
    check("held_gap_busy", busy1, 0);
    check("held_gap_done", done1, 0);
    @(negedge clk);
    check("held_reaccept_busy", busy1, 1);
    start1 = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk); lat++;
      if (done1) seen = 1;
    end
    check("held_second_done", 32'(seen), 1);

    // reset at the 4th CALC cycle aborts the operation
    @(negedge clk);
    a1 = 8'h12; b1 = 8'h34; bin1 = 0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", busy1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_d", d1, 0);
    check("abort_bout", bout1, 0);
    repeat (12) @(negedge clk);
    check("abort_idle", busy1, 0);
    run_op(0, 8'hAA, 8'h55, 0, '{d: 8'h55, bout: 1'b0, ovf: 1'b1}, "s1_AAm55");

    run_op(1, 8'hF0, 8'h0F, 0, '{d: 8'hE1, bout: 1'b0, ovf: 1'b0}, "s4_F0m0F");
    run_op(1, 8'h00, 8'hFF, 1, '{d: 8'h00, bout: 1'b1, ovf: 1'b0}, "s4_00mFFb");
    run_op(1, 8'h7F, 8'hFF, 0, '{d: 8'h80, bout: 1'b1, ovf: 1'b1}, "s4_7FmFF");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rbin = 1'($urandom_range(0, 1));
      run_op(1, ra, rb, rbin, model(ra, rb, rbin), "s4_rand");
    end
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255)); rbin = 1'($urandom_range(0, 1));
      run_op(0, ra, rb, rbin, model(ra, rb, rbin), "s1_rand");
    end

    repeat (4) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
